stage_queue: RTL and testbench

- Parametrised, multi-lane elastic queue that replaces a fixed single-bundle stage register between two superscalar pipeline stages (e.g. fetch→decode, decode→rename).
- Accepts up to WIDTH lane-packed entries per cycle and presents the oldest up to WIDTH entries in order.
- The consumer takes a variable count per cycle, so partial consumption under hazard stalls needs no replay.
- A flush input empties the queue on redirect or exception.

---
 rtl/stage_queue.sv | 137 +++++++++++++
 tb/tb_stage_queue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/stage_queue.sv
// stage_queue: multi-lane elastic queue placed between two superscalar
// pipeline stages. Up to WIDTH lane-packed entries are accepted per cycle,
// and the oldest WIDTH entries are presented in order. The consumer may take
// any count per cycle up to the number presented, and flush empties the queue.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset (empties the queue at once)
//   in_valid   per-lane valid of incoming bundle, lane 0 oldest
//   in_data    incoming payloads, lane i at [i*DATA_W +: DATA_W]
//   in_ready   a full WIDTH bundle can be accepted this cycle
//   out_valid  prefix mask of presented entries, lane 0 oldest
//   out_data   presented payloads, same packing as in_data
//   out_take   number of presented entries consumed this cycle (clamped)
//   flush      discard all contents, including a same-cycle push
//   count      current occupancy
//
// DEPTH must be a power of two and at least 2*WIDTH.
module stage_queue #(
  parameter int DATA_W = 64,
  parameter int WIDTH  = 2,
  parameter int DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             in_valid,
  input  logic [WIDTH*DATA_W-1:0]      in_data,
  output logic                         in_ready,
  output logic [WIDTH-1:0]             out_valid,
  output logic [WIDTH*DATA_W-1:0]      out_data,
  input  logic [$clog2(WIDTH+1)-1:0]   out_take,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int TAKE_W = $clog2(WIDTH+1);

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [TAKE_W-1:0] n_push;
  logic [CNT_W-1:0]  n_take;
  logic [CNT_W-1:0]  take_ext;
  logic [CNT_W-1:0]  free_slots;
  logic              run;
  logic [WIDTH-1:0]  wr_en;
  logic [PTR_W-1:0]  wr_idx [WIDTH];
  logic [PTR_W-1:0]  rd_idx [WIDTH];

  // Ready depends only on registered occupancy, so no path from out_take or
  // flush reaches in_ready. count_q never exceeds DEPTH, so no underflow.
  assign free_slots = CNT_W'(DEPTH) - count_q;
  assign in_ready   = free_slots >= CNT_W'(WIDTH);
  assign count      = count_q;

  // Only the contiguous run of valid lanes starting at lane 0 is accepted;
  // anything after the first hole is ignored.
  always_comb begin
    n_push = '0;
    run    = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      run = run & in_valid[i];
      if (run) n_push = n_push + TAKE_W'(1);
    end
    if (!in_ready) n_push = '0;
  end

  // Write lanes land at consecutive slots from tail; the pointer add wraps
  // naturally because DEPTH is a power of two.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      wr_idx[i] = tail_q + PTR_W'(i);
      wr_en[i]  = (TAKE_W'(i) < n_push) && !flush;
    end
  end

  // Presentation reads straight from storage at head; entries pushed this
  // cycle only become visible once count_q has been updated.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rd_idx[i]                    = head_q + PTR_W'(i);
      out_valid[i]                 = CNT_W'(i) < count_q;
      out_data[i*DATA_W +: DATA_W] = mem[rd_idx[i]];
    end
  end

  // Over-asking consumers are clamped to what is actually held.
  always_comb begin
    take_ext = CNT_W'(out_take);
    n_take   = (take_ext > count_q) ? count_q : take_ext;
  end

  // Push and pop apply together; flush overrides both.
  always_comb begin
    head_d  = head_q + PTR_W'(n_take);
    tail_d  = tail_q + PTR_W'(n_push);
    count_d = count_q + CNT_W'(n_push) - n_take;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (wr_en[i]) mem[wr_idx[i]] <= in_data[i*DATA_W +: DATA_W];
    end
  end

  // Occupancy never exceeds capacity and agrees with the pointer distance
  // except when completely full (where head == tail again).
  assert property (@(posedge clk) disable iff (reset)
    count_q <= CNT_W'(DEPTH));
  assert property (@(posedge clk) disable iff (reset)
    (count_q == CNT_W'(DEPTH)) || (PTR_W'(count_q) == PTR_W'(tail_q - head_q)));

endmodule

// File: tb/tb_stage_queue.sv
// tb_stage_queue: directed bench for stage_queue (WIDTH=2, DEPTH=8,
// DATA_W=32). A queue-based reference model tracks the expected contents and
// is compared against the DUT on every falling edge; directed scenarios add
// hand-computed literal expectations.
module tb_stage_queue;

  localparam int DATA_W = 32;
  localparam int WIDTH  = 2;
  localparam int DEPTH  = 8;

  logic                    clk;
  logic                    reset;
  logic [WIDTH-1:0]        in_valid;
  logic [WIDTH*DATA_W-1:0] in_data;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_valid;
  logic [WIDTH*DATA_W-1:0] out_data;
  logic [1:0]              out_take;
  logic                    flush;
  logic [3:0]              count;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] model_q [$];

  stage_queue #(.DATA_W(DATA_W), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_take  (out_take),
    .flush     (flush),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: every check in the bench funnels through here.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, let the rising edge take them, then settle.
  task automatic applyStimulus(input logic [1:0] v, input logic [31:0] d0,
                               input logic [31:0] d1, input logic [1:0] take,
                               input logic fl);
    in_valid = v;
    in_data  = {d1, d0};
    out_take = take;
    flush    = fl;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a plain FIFO of payloads. Pops are limited by what was
  // held before this edge; pushes only happen when at least WIDTH slots are
  // free, and only the leading run of valid lanes is taken.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_q.delete();
    end else if (flush) begin
      model_q.delete();
    end else begin
      int held;
      int ntake;
      bit room;
      held  = model_q.size();
      room  = (DEPTH - held) >= WIDTH;
      ntake = (int'(out_take) < held) ? int'(out_take) : held;
      for (int k = 0; k < ntake; k++) void'(model_q.pop_front());
      if (room && in_valid[0]) begin
        model_q.push_back(in_data[31:0]);
        if (in_valid[1]) model_q.push_back(in_data[63:32]);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      int sz;
      logic [1:0] exp_valid;
      sz = model_q.size();
      exp_valid = 2'b00;
      for (int i = 0; i < WIDTH; i++) exp_valid[i] = (i < sz);
      checkOutput("model_count", 64'(count), 64'(sz));
      checkOutput("model_in_ready", 64'(in_ready), 64'((DEPTH - sz) >= WIDTH));
      checkOutput("model_out_valid", 64'(out_valid), 64'(exp_valid));
      for (int i = 0; i < WIDTH; i++) begin
        if (i < sz)
          checkOutput($sformatf("model_lane%0d_data", i),
                      64'(out_data[i*DATA_W +: DATA_W]), 64'(model_q[i]));
      end
    end
  end

  initial begin
    reset    = 1'b1;
    in_valid = '0;
    in_data  = '0;
    out_take = '0;
    flush    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    checkOutput("reset_count", 64'(count), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);

    // Basic push then partial pop.
    applyStimulus(2'b11, 32'hA, 32'hB, 2'd0, 1'b0);
    checkOutput("basic_count", 64'(count), 64'd2);
    checkOutput("basic_valid", 64'(out_valid), 64'b11);
    checkOutput("basic_lane0", 64'(out_data[31:0]), 64'hA);
    checkOutput("basic_lane1", 64'(out_data[63:32]), 64'hB);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'd1, 1'b0);
    checkOutput("pop1_valid", 64'(out_valid), 64'b01);
    checkOutput("pop1_lane0", 64'(out_data[31:0]), 64'hB);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
    checkOutput("drain_count", 64'(count), 64'd0);

    // Fill to capacity, hold a full bundle while full, then release slowly.
    for (int k = 0; k < 4; k++)
      applyStimulus(2'b11, 32'h100 + 32'(2*k), 32'h101 + 32'(2*k), 2'd0, 1'b0);
    checkOutput("full_count", 64'(count), 64'd8);
    checkOutput("full_in_ready", 64'(in_ready), 64'd0);
    applyStimulus(2'b11, 32'hDEAD, 32'hBEEF, 2'd0, 1'b0);
    checkOutput("full_hold_count", 64'(count), 64'd8);
    checkOutput("full_hold_lane0", 64'(out_data[31:0]), 64'h100);
    applyStimulus(2'b11, 32'hDEAD, 32'hBEEF, 2'd1, 1'b0);
    checkOutput("take1_count", 64'(count), 64'd7);
    checkOutput("take1_in_ready", 64'(in_ready), 64'd0);
    applyStimulus(2'b11, 32'hDEAD, 32'hBEEF, 2'd1, 1'b0);
    checkOutput("take2_count", 64'(count), 64'd6);
    checkOutput("take2_in_ready", 64'(in_ready), 64'd1);
    checkOutput("take2_lane0", 64'(out_data[31:0]), 64'h102);
    for (int k = 0; k < 3; k++) applyStimulus(2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
    checkOutput("full_drain_count", 64'(count), 64'd0);

    // Streaming: push two sequence numbers per cycle, consume two per cycle.
    for (int k = 0; k < 12; k++) begin
      applyStimulus(2'b11, 32'(2*k), 32'(2*k+1), (k == 0) ? 2'd0 : 2'd2, 1'b0);
      checkOutput($sformatf("stream%0d_count", k), 64'(count), 64'd2);
      checkOutput($sformatf("stream%0d_lane0", k), 64'(out_data[31:0]), 64'(2*k));
      checkOutput($sformatf("stream%0d_lane1", k), 64'(out_data[63:32]), 64'(2*k+1));
    end
    applyStimulus(2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
    checkOutput("stream_end_count", 64'(count), 64'd0);

    // Flush beats a same-cycle push and take.
    applyStimulus(2'b11, 32'h11, 32'h12, 2'd0, 1'b0);
    applyStimulus(2'b11, 32'h13, 32'h14, 2'd0, 1'b0);
    applyStimulus(2'b01, 32'h15, 32'h0, 2'd0, 1'b0);
    checkOutput("preflush_count", 64'(count), 64'd5);
    applyStimulus(2'b11, 32'hEE, 32'hFF, 2'd2, 1'b1);
    checkOutput("flush_count", 64'(count), 64'd0);
    checkOutput("flush_valid", 64'(out_valid), 64'd0);
    applyStimulus(2'b01, 32'h55, 32'h0, 2'd0, 1'b0);
    checkOutput("postflush_count", 64'(count), 64'd1);
    checkOutput("postflush_lane0", 64'(out_data[31:0]), 64'h55);

    // Malformed valid mask and over-large take.
    applyStimulus(2'b10, 32'h66, 32'h67, 2'd2, 1'b0);
    checkOutput("malformed_count", 64'(count), 64'd0);
    applyStimulus(2'b01, 32'h77, 32'h0, 2'd0, 1'b0);
    checkOutput("lane0_only_count", 64'(count), 64'd1);
    checkOutput("lane0_only_lane0", 64'(out_data[31:0]), 64'h77);

    // Asynchronous reset mid-cycle with five entries held.
    applyStimulus(2'b11, 32'h81, 32'h82, 2'd0, 1'b0);
    applyStimulus(2'b11, 32'h83, 32'h84, 2'd0, 1'b0);
    in_valid = 2'b00;
    checkOutput("prereset_count", 64'(count), 64'd5);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_count", 64'(count), 64'd0);
    checkOutput("async_reset_valid", 64'(out_valid), 64'd0);
    checkOutput("async_reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(2'b11, 32'h91, 32'h92, 2'd0, 1'b0);
    checkOutput("after_reset_count", 64'(count), 64'd2);
    checkOutput("after_reset_lane0", 64'(out_data[31:0]), 64'h91);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
